// File: rtl/alu_issue.sv
// alu_issue: command FIFO in front of an external combinational ALU, with a
// registered result stage and a completed-transfer counter.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      command handshake; in_a, in_b, in_op form the command
//   alu_a, alu_b, alu_op   FIFO head presented to the external ALU
//   alu_res, alu_carry     combinational ALU result for the FIFO head
//   out_valid/out_ready    result handshake; out_res, out_carry, out_op hold it
//   done_cnt               16-bit wrapping count of completed result transfers

package enums_pkg;
   typedef enum logic [2:0] {
      NOP    = 3'd0,
      ADD    = 3'd1,
      SUB    = 3'd2,
      AND    = 3'd3,
      OR     = 3'd4,
      XOR    = 3'd5,
      SHIFTL = 3'd6,
      SHIFTR = 3'd7
   } OP_CODE;
endpackage

module alu_issue
   import enums_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   input  OP_CODE      in_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output OP_CODE      alu_op,
   input  logic [7:0]  alu_res,
   input  logic        alu_carry,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_res,
   output logic        out_carry,
   output OP_CODE      out_op,
   output logic [15:0] done_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   logic [7:0] mem_a  [DEPTH];
   logic [7:0] mem_b  [DEPTH];
   OP_CODE     mem_op [DEPTH];

   logic not_empty;
   logic push;
   logic pop;

   // in_ready looks only at the registered count, so a full FIFO refuses a
   // push even when a pop frees a slot on the same edge.
   assign not_empty = (count != '0);
   assign in_ready  = (count < DEPTH_C);
   assign push      = in_valid && in_ready;
   assign pop       = not_empty && (!out_valid || out_ready);

   // The head entry feeds the ALU directly; an empty FIFO presents a NOP
   // with zero operands so the ALU inputs never show stale entries.
   always_comb begin
      alu_a  = 8'h00;
      alu_b  = 8'h00;
      alu_op = NOP;
      if (not_empty) begin
         alu_a  = mem_a[rd_ptr];
         alu_b  = mem_b[rd_ptr];
         alu_op = mem_op[rd_ptr];
      end
   end

   // Storage needs no reset: entries are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= in_a;
         mem_b[wr_ptr]  <= in_b;
         mem_op[wr_ptr] <= in_op;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A pop captures the ALU result for the head; otherwise a completed
   // handshake empties the output stage and a stalled one holds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_res   <= 8'h00;
         out_carry <= 1'b0;
         out_op    <= NOP;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_res   <= alu_res;
         out_carry <= alu_carry;
         out_op    <= alu_op;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= 16'h0000;
      end else if (out_valid && out_ready) begin
         done_cnt <= done_cnt + 16'h0001;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a reference ALU model,
// a result scoreboard and immediate-assertion checks.

module tb_alu_issue;
   import enums_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   OP_CODE      in_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   OP_CODE      alu_op;
   logic [7:0]  alu_res;
   logic        alu_carry;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_res;
   logic        out_carry;
   OP_CODE      out_op;
   logic [15:0] done_cnt;

   int compared   = 0;
   int mismatched = 0;
   int pop_cnt    = 0;

   logic [11:0] sb[$];
   logic [11:0] sb_entry;

   alu_issue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_res   (alu_res),
      .alu_carry (alu_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_carry (out_carry),
      .out_op    (out_op),
      .done_cnt  (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {carry, result}; SUB carry is the borrow.
   function automatic logic [8:0] aluModel(input logic [7:0] a, input logic [7:0] b, input OP_CODE op);
      logic [8:0] r;
      r = 9'h000;
      case (op)
         ADD:     r = {1'b0, a} + {1'b0, b};
         SUB:     r = {(a < b), a - b};
         AND:     r = {1'b0, a & b};
         OR:      r = {1'b0, a | b};
         XOR:     r = {1'b0, a ^ b};
         SHIFTL:  r = {a[7], a[6:0], 1'b0};
         SHIFTR:  r = {a[0], 1'b0, a[7:1]};
         default: r = 9'h000;
      endcase
      return r;
   endfunction

   always_comb {alu_carry, alu_res} = aluModel(alu_a, alu_b, alu_op);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input OP_CODE op);
      @(posedge clk);
      #1;
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_op    = op;
   endtask

   task automatic setReady(input logic r);
      @(posedge clk);
      #1;
      out_ready = r;
   endtask

   task automatic waitDrain(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_drain"}, 32'(ok), 32'd1);
   endtask

   task automatic directedOne(input string tag, input logic [7:0] a, input logic [7:0] b, input OP_CODE op,
                              input logic [7:0] eres, input logic ecarry, input logic [15:0] edone);
      applyStimulus(1'b1, a, b, op);
      applyStimulus(1'b0, 8'h00, 8'h00, NOP);
      @(negedge clk);
      checkOutput({tag, "_lat0_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_head_op"}, 32'(alu_op), 32'(op));
      @(negedge clk);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_res"}, 32'(out_res), 32'(eres));
      checkOutput({tag, "_carry"}, 32'(out_carry), 32'(ecarry));
      checkOutput({tag, "_op"}, 32'(out_op), 32'(op));
      @(negedge clk);
      checkOutput({tag, "_done"}, 32'(done_cnt), 32'(edone));
      checkOutput({tag, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   // Scoreboard: push expected on each accepted command, compare on each
   // completed result transfer. Sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("sb_unexpected", 32'd1, 32'd0);
            end else begin
               sb_entry = sb.pop_front();
               checkOutput("sb_result", {20'h0, out_op, out_carry, out_res}, {20'h0, sb_entry});
               pop_cnt++;
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back({in_op, aluModel(in_a, in_b, in_op)});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int pc;
      int stalls;
      int bad_ready;
      logic [7:0] held;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = 8'h00;
      in_b      = 8'h00;
      in_op     = NOP;
      out_ready = 1'b0;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
      checkOutput("rst_out_op", 32'(out_op), 32'(NOP));
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed single commands
      setReady(1'b1);
      directedOne("add", 8'hF0, 8'h20, ADD, 8'h10, 1'b1, 16'd1);
      directedOne("sub", 8'h05, 8'h07, SUB, 8'hFE, 1'b1, 16'd2);
      directedOne("shr", 8'h81, 8'h00, SHIFTR, 8'h40, 1'b1, 16'd3);

      // Backpressure: five accepted (one held, four queued), sixth stalls
      setReady(1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), OP_CODE'(3'($urandom_range(1, 7))));
      end
      applyStimulus(1'b1, 8'hAA, 8'h55, XOR);
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_queued", 32'(sb.size()), 32'd5);
      held = sb[0][7:0];
      checkOutput("bp_held_first", 32'(out_res), 32'(held));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), OP_CODE'(3'($urandom)));
         @(negedge clk);
         checkOutput("bp_held_stable", 32'(out_res), 32'(held));
      end
      applyStimulus(1'b0, 8'h00, 8'h00, NOP);
      pc = pop_cnt;
      setReady(1'b1);
      waitDrain("bp");
      checkOutput("bp_result_count", 32'(pop_cnt - pc), 32'd5);

      // Streaming 100 commands, one result per clock
      pc = pop_cnt;
      stalls = 0;
      bad_ready = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 0)      applyStimulus(1'b1, 8'h05, 8'h07, SUB);
         else if (i == 1) applyStimulus(1'b1, 8'h81, 8'h3C, SHIFTR);
         else             applyStimulus(1'b1, 8'($urandom), 8'($urandom), OP_CODE'(3'($urandom)));
         @(negedge clk);
         if (!in_ready) bad_ready++;
         if (i >= 2 && !out_valid) stalls++;
      end
      applyStimulus(1'b0, 8'h00, 8'h00, NOP);
      waitDrain("stream");
      checkOutput("stream_stalls", 32'(stalls), 32'd0);
      checkOutput("stream_in_ready", 32'(bad_ready), 32'd0);
      checkOutput("stream_count", 32'(pop_cnt - pc), 32'd100);

      // Empty FIFO and idle input toggling
      @(negedge clk);
      checkOutput("empty_alu_op", 32'(alu_op), 32'(NOP));
      checkOutput("empty_alu_a", 32'(alu_a), 32'd0);
      checkOutput("empty_alu_b", 32'(alu_b), 32'd0);
      checkOutput("empty_done", 32'(done_cnt), 32'd108);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 8'($urandom), 8'($urandom), OP_CODE'(3'($urandom)));
      end
      @(negedge clk);
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle_done", 32'(done_cnt), 32'd108);
      checkOutput("idle_alu_op", 32'(alu_op), 32'(NOP));
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b0, 8'h00, 8'h00, NOP);

      // Reset with one held and three queued
      setReady(1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), ADD);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, NOP);
      @(negedge clk);
      checkOutput("mid_rst_pre_valid", 32'(out_valid), 32'd1);
      checkOutput("mid_rst_pre_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("mid_rst_done", 32'(done_cnt), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      setReady(1'b1);
      repeat (10) @(negedge clk);
      checkOutput("post_rst_no_stale", 32'(out_valid), 32'd0);
      checkOutput("post_rst_done", 32'(done_cnt), 32'd0);

      // done_cnt wrap
      @(negedge clk);
      force dut.done_cnt = 16'hFFFE;
      #2;
      release dut.done_cnt;
      applyStimulus(1'b1, 8'h01, 8'h02, ADD);
      applyStimulus(1'b1, 8'h03, 8'h04, OR);
      applyStimulus(1'b0, 8'h00, 8'h00, NOP);
      waitDrain("wrap");
      checkOutput("wrap_done", 32'(done_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
